vec_ergodic: RTL and testbench

Nested-loop address generator that walks every (image vector, library vector) pair exactly once, in row-major order: image index outer, library index inner. It sits in front of the vector-compare datapath, presents one address pair per cycle under a valid/ready handshake, and flags the end of each inner row and the end of the full sweep.

---
 rtl/vec_ergodic_pkg.sv | 16 +
 rtl/vec_ergodic_wrap.sv | 31 +++
 rtl/vec_ergodic.sv | 97 +++++++++
 tb/tb_vec_ergodic.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_ergodic_pkg.sv
// Shared types and helpers for the vec_ergodic address generator.
// Holds the FSM state encoding and the index-width helper.
package vec_ergodic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-entry loop still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_ergodic_wrap.sv
// wrap_counter: modulo-N counter, 0..N-1; cnt is registered, and wrap flags an enabled step at N-1.
// clr has priority over en and forces the count back to zero.
module wrap_counter
    import vec_ergodic_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vec_ergodic.sv
// Row-major (image outer, library inner) pair address generator; one pair per cycle when ready is high.
// Holds the pair while ready is low. Optional macro VEC_ERGODIC_STICKY_FINISH_EN keeps finish high until the next start.
module vec_ergodic
    import vec_ergodic_pkg::*;
#(
    parameter int IMG_VEC_N = 5,
    parameter int LIB_VEC_N = 20,
    localparam int IW = idx_w(IMG_VEC_N),
    localparam int LW = idx_w(LIB_VEC_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] img_addr,
    output logic [LW-1:0] lib_addr,
    output logic          linefeed,
    output logic          finish
);

    state_t state;
    logic   hs;
    logic   load;
    logic   lib_wrap;
    logic   img_wrap;

    assign hs   = valid && ready;
    assign load = (state == IDLE) && start;

    wrap_counter #(.N(LIB_VEC_N), .W(LW)) u_lib (
        .clk  (clk),
        .rst  (rst),
        .en   (hs),
        .clr  (load),
        .cnt  (lib_addr),
        .wrap (lib_wrap)
    );

    // Outer index only advances when the inner row wraps; its wrap marks the final pair.
    wrap_counter #(.N(IMG_VEC_N), .W(IW)) u_img (
        .clk  (clk),
        .rst  (rst),
        .en   (lib_wrap),
        .clr  (load),
        .cnt  (img_addr),
        .wrap (img_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            linefeed <= 1'b0;
        end else begin
            linefeed <= lib_wrap;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (img_wrap) begin
                        state <= DONE;
                        valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish <= 1'b0;
        end else begin
`ifdef VEC_ERGODIC_STICKY_FINISH_EN
            if (img_wrap) begin
                finish <= 1'b1;
            end else if (load) begin
                finish <= 1'b0;
            end
`else
            finish <= img_wrap;
`endif
        end
    end

endmodule

// File: tb/tb_vec_ergodic.sv
// Scoreboard bench: stimulus queues expected pairs, a negedge monitor pops and checks them.
// A second 1x1 instance covers the degenerate size.
module tb_vec_ergodic;

    localparam int IMG = 5;
    localparam int LIB = 20;
    localparam int TOTAL = IMG * LIB;
`ifdef VEC_ERGODIC_STICKY_FINISH_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        int img;
        int lib;
        bit row_end;
        bit last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, ready_a, valid_a, linefeed_a, finish_a;
    logic [2:0] img_a;
    logic [4:0] lib_a;
    logic       start_b, ready_b, valid_b, linefeed_b, finish_b;
    logic [0:0] img_b;
    logic [0:0] lib_b;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   lf_due  = 1'b0;
    bit   fin_due = 1'b0;

    always #5 clk = ~clk;

    vec_ergodic #(.IMG_VEC_N(IMG), .LIB_VEC_N(LIB)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .ready    (ready_a),
        .valid    (valid_a),
        .img_addr (img_a),
        .lib_addr (lib_a),
        .linefeed (linefeed_a),
        .finish   (finish_a)
    );

    vec_ergodic #(.IMG_VEC_N(1), .LIB_VEC_N(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .ready    (ready_b),
        .valid    (valid_b),
        .img_addr (img_b),
        .lib_addr (lib_b),
        .linefeed (linefeed_b),
        .finish   (finish_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pulses owed by last cycle's handshake, then the presented pair.
    always @(negedge clk) begin
        if (rst) begin
            lf_due  = 1'b0;
            fin_due = 1'b0;
        end else begin
            chk("linefeed", int'(linefeed_a), int'(lf_due));
            if (fin_due) chk("finish_pulse", int'(finish_a), 1);
            else if (!STICKY) chk("finish_idle_low", int'(finish_a), 0);
            lf_due  = 1'b0;
            fin_due = 1'b0;
            if (valid_a) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("img_addr", int'(img_a), q[0].img);
                    chk("lib_addr", int'(lib_a), q[0].lib);
                    if (ready_a) begin
                        lf_due  = q[0].row_end;
                        fin_due = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // stall_at/stall_len: cycles with ready low; rst_at: accepted-pair count at which to reset;
    // start_run_at: cycle of a stray start pulse during RUN (negative = none).
    task automatic sweep(input int stall_at, input int stall_len, input int rst_at, input int start_run_at);
        int acc;
        int c;
        for (int i = 0; i < IMG; i++)
            for (int j = 0; j < LIB; j++)
                q.push_back('{i, j, (j == LIB - 1), (i == IMG - 1) && (j == LIB - 1)});
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        acc = 0;
        c   = 0;
        while (acc < TOTAL) begin
            start_a = (c == 0) || (c == start_run_at);
            ready_a = !((c >= stall_at) && (c < stall_at + stall_len));
            if (acc == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", int'(valid_a), 0);
                chk("rst_img", int'(img_a), 0);
                chk("rst_lib", int'(lib_a), 0);
                chk("rst_linefeed", int'(linefeed_a), 0);
                chk("rst_finish", int'(finish_a), 0);
                start_a = 1'b0;
                ready_a = 1'b0;
                tick();
                rst = 1'b0;
                q.delete();
                tick();
                chk("post_rst_valid", int'(valid_a), 0);
                return;
            end
            tick();
            if (ready_a) acc++;
            c++;
        end
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("done_valid", int'(valid_a), 0);
        tick();
        tick();
        chk("idle_valid", int'(valid_a), 0);
        chk("idle_finish", int'(finish_a), int'(STICKY));
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_valid", int'(valid_a), 0);
        chk("reset_img", int'(img_a), 0);
        chk("reset_lib", int'(lib_a), 0);
        chk("reset_linefeed", int'(linefeed_a), 0);
        chk("reset_finish", int'(finish_a), 0);

        sweep(-10, 0, -1, 50);   // full run, stray start mid-sweep
        sweep(7, 2, -1, -1);     // hold at (0,7)
        sweep(19, 2, -1, -1);    // hold at row end (0,19)
        sweep(-10, 0, 43, -1);   // reset at (2,3)
        sweep(-10, 0, -1, -1);   // restart from (0,0)

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_valid", int'(valid_b), 1);
        chk("b_img", int'(img_b), 0);
        chk("b_lib", int'(lib_b), 0);
        chk("b_finish_run", int'(finish_b), 0);
        tick();
        chk("b_hold_valid", int'(valid_b), 1);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        chk("b_done_valid", int'(valid_b), 0);
        chk("b_linefeed", int'(linefeed_b), 1);
        chk("b_finish", int'(finish_b), 1);
        tick();
        chk("b_linefeed_after", int'(linefeed_b), 0);
        chk("b_finish_after", int'(finish_b), int'(STICKY));
        tick();
        chk("b_finish_idle", int'(finish_b), int'(STICKY));
        chk("b_idle_valid", int'(valid_b), 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_restart_valid", int'(valid_b), 1);
        chk("b_restart_finish", int'(finish_b), 0);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        chk("b_second_finish", int'(finish_b), 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
